// File: rtl/fighter_pkg.sv
// Shared types and constants for the per-player fighter movement blocks.
package fighter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    CROUCH = 2'd2,
    AIR    = 2'd3
  } motion_state_t;

  localparam logic [7:0] DEF_KEY_UP    = 8'h0c;
  localparam logic [7:0] DEF_KEY_LEFT  = 8'h0d;
  localparam logic [7:0] DEF_KEY_DOWN  = 8'h0e;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h0f;

  localparam int POS_W  = 10;
  localparam int CALC_W = 12;
endpackage

// File: rtl/fighter_key_decode.sv
// Matches every keycode slot against the four movement keys; purely combinational.
module fighter_key_decode
  import fighter_pkg::*;
#(
  parameter int         NUM_KEYS  = 4,
  parameter logic [7:0] KEY_LEFT  = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_DOWN  = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_UP    = DEF_KEY_UP
) (
  input  logic [NUM_KEYS*8-1:0] keycodes,
  output logic                  pressed_left,
  output logic                  pressed_right,
  output logic                  pressed_down,
  output logic                  pressed_up
);
  always_comb begin
    pressed_left  = 1'b0;
    pressed_right = 1'b0;
    pressed_down  = 1'b0;
    pressed_up    = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycodes[8*i +: 8] == KEY_LEFT)  pressed_left  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_RIGHT) pressed_right = 1'b1;
      if (keycodes[8*i +: 8] == KEY_DOWN)  pressed_down  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_UP)    pressed_up    = 1'b1;
    end
  end
endmodule

// File: rtl/fighter_motion.sv
// Per-player walk/crouch/jump controller with jump physics, knockback and screen clamp.
// Keys sampled at a frame edge take effect in the registered position at that same edge.
module fighter_motion
  import fighter_pkg::*;
#(
  parameter int         NUM_KEYS   = 4,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_DOWN   = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_UP     = DEF_KEY_UP,
  parameter int         X_START    = 480,
  parameter int         Y_GROUND   = 170,
  parameter int         X_MIN      = 0,
  parameter int         X_MAX      = 637,
  parameter int         WIDTH      = 125,
  parameter int         WALK_SPEED = 2,
  parameter int         JUMP_V0    = 12,
  parameter int         GRAVITY    = 1,
  parameter int         MIN_SEP    = 105,
  parameter int         FACE_LEFT  = 1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [NUM_KEYS*8-1:0]   keycodes,
  input  logic signed [10:0]      x_dist,
  input  logic signed [7:0]       knockback,
  output logic [POS_W-1:0]        pos_x,
  output logic [POS_W-1:0]        pos_y,
  output logic [1:0]              state,
  output logic                    airborne
);
  localparam logic signed [CALC_W-1:0] X_LO   = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] X_HI   = CALC_W'(X_MAX - WIDTH);
  localparam logic signed [CALC_W-1:0] Y_GND  = CALC_W'(Y_GROUND);
  localparam logic signed [CALC_W-1:0] WALK_V = CALC_W'(WALK_SPEED);
  localparam logic signed [CALC_W-1:0] JUMP_V = CALC_W'(JUMP_V0);
  localparam logic signed [CALC_W-1:0] GRAV   = CALC_W'(GRAVITY);
  localparam logic signed [10:0]       SEP_LIM = 11'(MIN_SEP);

  logic pressed_left, pressed_right, pressed_down, pressed_up;

  fighter_key_decode #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_LEFT (KEY_LEFT),
    .KEY_RIGHT(KEY_RIGHT),
    .KEY_DOWN (KEY_DOWN),
    .KEY_UP   (KEY_UP)
  ) u_keys (
    .keycodes     (keycodes),
    .pressed_left (pressed_left),
    .pressed_right(pressed_right),
    .pressed_down (pressed_down),
    .pressed_up   (pressed_up)
  );

  motion_state_t            st_q, st_nxt;
  logic [POS_W-1:0]         px_q, py_q, px_nxt, py_nxt;
  logic signed [CALC_W-1:0] vx_q, vy_q, vx_nxt, vy_nxt;
  logic signed [CALC_W-1:0] walk_vx, y_sum, x_sum;
  logic                     blocked, go_left, go_right;

  always_comb begin
    blocked  = (x_dist <= SEP_LIM);
    // Only the direction facing the opponent is subject to the separation limit.
    go_left  = pressed_left & ~pressed_right & ~(blocked & (FACE_LEFT != 0));
    go_right = pressed_right & ~pressed_left & ~(blocked & (FACE_LEFT == 0));
    walk_vx  = '0;
    if (go_left)       walk_vx = -WALK_V;
    else if (go_right) walk_vx = WALK_V;

    st_nxt = st_q;
    vx_nxt = vx_q;
    vy_nxt = vy_q;
    py_nxt = py_q;
    y_sum  = $signed({{(CALC_W-POS_W){1'b0}}, py_q}) + vy_q;

    if (st_q == AIR) begin
      if (y_sum >= Y_GND) begin
        py_nxt = POS_W'(Y_GROUND);
        vy_nxt = '0;
        st_nxt = IDLE;
      end else begin
        py_nxt = y_sum[POS_W-1:0];
        vy_nxt = vy_q + GRAV;
      end
    end else if (pressed_up) begin
      st_nxt = AIR;
      vy_nxt = -JUMP_V;
      vx_nxt = walk_vx;
    end else if (pressed_down) begin
      st_nxt = CROUCH;
      vx_nxt = '0;
    end else if (walk_vx != '0) begin
      st_nxt = WALK;
      vx_nxt = walk_vx;
    end else begin
      st_nxt = IDLE;
      vx_nxt = '0;
    end

    x_sum = $signed({{(CALC_W-POS_W){1'b0}}, px_q}) + vx_nxt
          + $signed({{(CALC_W-8){knockback[7]}}, knockback});
    if (x_sum < X_LO)      px_nxt = POS_W'(X_MIN);
    else if (x_sum > X_HI) px_nxt = POS_W'(X_MAX - WIDTH);
    else                   px_nxt = x_sum[POS_W-1:0];
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st_q <= IDLE;
      px_q <= POS_W'(X_START);
      py_q <= POS_W'(Y_GROUND);
      vx_q <= '0;
      vy_q <= '0;
    end else begin
      st_q <= st_nxt;
      px_q <= px_nxt;
      py_q <= py_nxt;
      vx_q <= vx_nxt;
      vy_q <= vy_nxt;
    end
  end

  assign pos_x    = px_q;
  assign pos_y    = py_q;
  assign state    = st_q;
  assign airborne = (st_q == AIR);
endmodule

// File: tb/tb_fighter_motion.sv
// Table vectors, hand-written jump sequences and randomized frames against an arithmetic model.
module tb_fighter_motion;
  localparam int S_IDLE = 0, S_WALK = 1, S_CROUCH = 2, S_AIR = 3;

  logic               frame_clk = 1'b0;
  logic               Reset = 1'b1;
  logic [31:0]        keycodes = '0;
  logic signed [10:0] x_dist = '0;
  logic signed [7:0]  knockback = '0;
  logic [9:0]         pos_x, pos_y;
  logic [1:0]         state;
  logic               airborne;

  fighter_motion dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .keycodes (keycodes),
    .x_dist   (x_dist),
    .knockback(knockback),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .state    (state),
    .airborne (airborne)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain integer physics
  int m_x, m_y, m_vx, m_vy, m_st;

  task automatic model_step(input logic [31:0] kc, input int xd, input int kb, input bit rst);
    bit l, r, u, d;
    int want;
    l = 0; r = 0; u = 0; d = 0; want = 0;
    for (int i = 0; i < 4; i++) begin
      case (kc[8*i +: 8])
        8'h0d: l = 1;
        8'h0f: r = 1;
        8'h0c: u = 1;
        8'h0e: d = 1;
        default: ;
      endcase
    end
    if (rst) begin
      m_x = 480; m_y = 170; m_vx = 0; m_vy = 0; m_st = S_IDLE;
      return;
    end
    if (m_st == S_AIR) begin
      if (m_y + m_vy >= 170) begin
        m_y = 170; m_vy = 0; m_st = S_IDLE;
      end else begin
        m_y = m_y + m_vy; m_vy = m_vy + 1;
      end
    end else begin
      if (l && !r)      want = (xd <= 105) ? 0 : -2;
      else if (r && !l) want = 2;
      if (u) begin
        m_st = S_AIR; m_vy = -12; m_vx = want;
      end else if (d) begin
        m_st = S_CROUCH; m_vx = 0;
      end else begin
        m_vx = want; m_st = (want != 0) ? S_WALK : S_IDLE;
      end
    end
    m_x = m_x + m_vx + kb;
    if (m_x < 0)   m_x = 0;
    if (m_x > 512) m_x = 512;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int es);
    check({tag, ".x"}, int'(pos_x), ex);
    check({tag, ".y"}, int'(pos_y), ey);
    check({tag, ".st"}, int'(state), es);
    check({tag, ".air"}, int'(airborne), (es == S_AIR) ? 1 : 0);
  endtask

  task automatic apply(input logic [31:0] kc, input int xd, input int kb, input bit rst);
    keycodes  = kc;
    x_dist    = xd[10:0];
    knockback = kb[7:0];
    Reset     = rst;
    @(posedge frame_clk);
    #1;
    model_step(kc, xd, kb, rst);
  endtask

  typedef struct {
    logic [31:0] kc;
    int xd; int kb; bit rst;
    int ex; int ey; int es;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [31:0] kc, input int xd, input int kb, input bit rst,
                              input int ex, input int ey, input int es);
    vec_t v;
    v.kc = kc; v.xd = xd; v.kb = kb; v.rst = rst;
    v.ex = ex; v.ey = ey; v.es = es;
    vecs.push_back(v);
  endfunction

  initial begin
    int ey, ex;
    logic [31:0] kc;
    int xd, kb;
    bit rst;

    // Reset and idle
    add(32'h0, 200, 0, 1, 480, 170, S_IDLE);
    for (int i = 0; i < 10; i++) add(32'h0, 200, 0, 0, 480, 170, S_IDLE);
    // Walk right (away) to the right bound
    for (int i = 1; i <= 16; i++) add(32'h000f0000, 200, 0, 0, 480 + 2*i, 170, S_WALK);
    for (int i = 0; i < 3; i++)   add(32'h000f0000, 200, 0, 0, 512, 170, S_WALK);
    // Toward-opponent walk blocked at the separation limit
    add(32'h0, 200, 0, 1, 480, 170, S_IDLE);
    add(32'h0000000d, 105, 0, 0, 480, 170, S_IDLE);
    add(32'h0000000d, 105, 0, 0, 480, 170, S_IDLE);
    add(32'h0000000d, 106, 0, 0, 478, 170, S_WALK);
    add(32'h0000000d, -5, 0, 0, 478, 170, S_IDLE);
    add(32'h000e0000, 200, 0, 0, 478, 170, S_CROUCH);
    // Knockback with clamp, then opposing keys cancel
    add(32'h0, 200, 0, 1, 480, 170, S_IDLE);
    for (int i = 1; i <= 10; i++) add(32'h0f000000, 200, 0, 0, 480 + 2*i, 170, S_WALK);
    add(32'h0, 200, 40, 0, 512, 170, S_IDLE);
    add(32'h00000d0f, 200, -8, 0, 504, 170, S_IDLE);
    add(32'h0, 200, -128, 0, 376, 170, S_IDLE);
    for (int i = 0; i < 4; i++) add(32'h0, 200, -128, 0, (i < 2) ? 248 - 128*i : 0, 170, S_IDLE);

    foreach (vecs[i]) begin
      apply(vecs[i].kc, vecs[i].xd, vecs[i].kb, vecs[i].rst);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es);
    end

    // Straight jump, DOWN/LEFT pressed mid-air are ignored
    apply(32'h0, 200, 0, 1);
    apply(32'h0000000c, 200, 0, 0);
    check_all("takeoff", 480, 170, S_AIR);
    for (int k = 1; k <= 25; k++) begin
      kc = (k >= 5 && k <= 8) ? 32'h0d0e0000 : 32'h0;
      apply(kc, 200, 0, 0);
      if (k < 25) check_all($sformatf("jump%0d", k), 480, 170 - (12*k - (k*(k-1))/2), S_AIR);
      else        check_all("land", 480, 170, S_IDLE);
      if (k == 1)             check("jump_first_y", int'(pos_y), 158);
      if (k == 12 || k == 13) check("jump_apex_y", int'(pos_y), 92);
    end
    apply(32'h0, 200, 0, 0);
    check_all("after_land", 480, 170, S_IDLE);

    // Jump with latched rightward drift, reset mid-air
    apply(32'h0, 300, 0, 1);
    apply(32'h00000c0f, 300, 0, 0);
    check_all("drift_takeoff", 482, 170, S_AIR);
    for (int k = 1; k <= 5; k++) begin
      apply(32'h0, 300, 0, 0);
      check_all($sformatf("drift%0d", k), 482 + 2*k, 170 - (12*k - (k*(k-1))/2), S_AIR);
    end
    apply(32'h0, 300, 0, 1);
    check_all("midair_reset", 480, 170, S_IDLE);
    apply(32'h0, 300, 0, 0);
    check_all("post_reset", 480, 170, S_IDLE);

    // Randomized frames against the model
    apply(32'h0, 200, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      kc = '0;
      for (int s = 0; s < 4; s++) begin
        case ($urandom_range(0, 11))
          6:  kc[8*s +: 8] = 8'h0c;
          7:  kc[8*s +: 8] = 8'h0d;
          8:  kc[8*s +: 8] = 8'h0e;
          9:  kc[8*s +: 8] = 8'h0f;
          10: kc[8*s +: 8] = 8'($urandom_range(0, 255));
          default: kc[8*s +: 8] = 8'h00;
        endcase
      end
      if ($urandom_range(0, 3) == 0) kc[8 +: 8] = 8'h0c;
      else if (kc[8 +: 8] == 8'h0c)  kc[8 +: 8] = 8'h00;
      xd  = int'($urandom_range(0, 420)) - 20;
      kb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 200)) - 100 : 0;
      rst = ($urandom_range(0, 299) == 0);
      apply(kc, xd, kb, rst);
      ex = m_x; ey = m_y;
      check_all($sformatf("rnd%0d", n), ex, ey, m_st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
